// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM state encoding,
// bus widths and a small address range helper.
package dmem_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int STRB_W = DATA_W / 8;
    localparam int CNT_W  = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Full-width compare so that addresses beyond the array never alias.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] addr,
                                           input int unsigned       depth);
        return (addr < ADDR_W'(depth));
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port word storage with synchronous byte-strobed write and
// combinational read; contents are intentionally not reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = 256
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        wdata,
    input  logic [STRB_W-1:0]        wstrb,
    output logic [DATA_W-1:0]        rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write only the byte lanes whose strobe bit is set.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (wstrb[b]) begin
                    mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one request at a time, waits LATENCY
// edges, then commits the write or samples the read and holds a registered
// response until the initiator takes it.
// Optional macro DMEM_RESPONDER_WSTRB_EN adds a req_wstrb byte-strobe port.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
`ifdef DMEM_RESPONDER_WSTRB_EN
    input  logic [STRB_W-1:0] req_wstrb,
`endif
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH);

    state_t              state;
    state_t              state_nxt;
    logic [CNT_W-1:0]    cnt;
    logic                accept;
    logic                commit;

    logic                we_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [STRB_W-1:0]   wstrb_q;
    logic                in_range;
    logic [DATA_W-1:0]   arr_rdata;

    assign in_range = addr_in_range(addr_q, DEPTH);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode plus the accept/commit strobes that drive the datapath.
    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept    = 1'b1;
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    commit    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Latency counter: loaded on accept, counts down to zero while waiting.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CNT_W'(LATENCY - 1);
        end else if (state == WAIT && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Capture the request fields at accept; they are only consumed at commit.
    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
`ifdef DMEM_RESPONDER_WSTRB_EN
            wstrb_q <= req_wstrb;
`else
            wstrb_q <= '1;
`endif
        end
    end

    // Registered response: built on the commit edge, held until consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (commit) begin
            rsp_valid <= 1'b1;
            rsp_err   <= ~in_range;
            rsp_rdata <= (!we_q && in_range) ? arr_rdata : '0;
        end else if (state == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    dmem_array #(
        .DEPTH (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (commit && we_q && in_range),
        .addr  (addr_q[IDX_W-1:0]),
        .wdata (wdata_q),
        .wstrb (wstrb_q),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder with a response scoreboard.
// Instance a: DEPTH=256, LATENCY=2.  Instance b: DEPTH=256, LATENCY=1.
module tb_dmem_responder;

    localparam int DEPTH = 256;
    localparam int LAT_A = 2;
    localparam int LAT_B = 1;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;

    logic        req_valid, req_ready, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid_b, req_ready_b, req_we_b;
    logic [31:0] req_addr_b, req_wdata_b;
    logic [3:0]  req_wstrb_b;
    logic        rsp_valid_b, rsp_ready_b, rsp_err_b;
    logic [31:0] rsp_rdata_b;

    exp_t sb[$];
    exp_t sb_b[$];

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT_A)) dut_a (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
`ifdef DMEM_RESPONDER_WSTRB_EN
        .req_wstrb (req_wstrb),
`endif
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err)
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT_B)) dut_b (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid_b),
        .req_ready (req_ready_b),
        .req_we    (req_we_b),
        .req_addr  (req_addr_b),
        .req_wdata (req_wdata_b),
`ifdef DMEM_RESPONDER_WSTRB_EN
        .req_wstrb (req_wstrb_b),
`endif
        .rsp_valid (rsp_valid_b),
        .rsp_ready (rsp_ready_b),
        .rsp_rdata (rsp_rdata_b),
        .rsp_err   (rsp_err_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One full transaction on instance a; hold>0 applies that many cycles of
    // response backpressure while stray requests are offered.
    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb,
                          input logic [31:0] exp_rdata, input logic exp_err,
                          input int hold);
        exp_t e;
        int   edges;
        @(negedge clk);
        chk({tag, " req_ready idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = strb;
        rsp_ready = (hold == 0);
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        edges = 0;
        while (!rsp_valid && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        chk({tag, " latency"}, 32'(edges), 32'(LAT_A));
        e = sb.pop_front();
        chk({tag, " rdata"}, rsp_rdata, e.rdata);
        chk({tag, " err"}, 32'(rsp_err), 32'(e.err));
        for (int i = 0; i < hold; i++) begin
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_wdata = ~wdata;
            @(negedge clk);
            chk({tag, " hold valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, " hold rdata"}, rsp_rdata, e.rdata);
            chk({tag, " hold req_ready"}, 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk({tag, " rsp_valid drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, " req_ready back"}, 32'(req_ready), 32'd1);
    endtask

    initial begin
        exp_t e;
        int   seen;
        int   issued;
        int   got;
        int   last;
        int   cyc;

        reset     = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_wstrb = 4'hF;
        rsp_ready = 1'b1;
        req_valid_b = 1'b0; req_we_b = 1'b0; req_addr_b = '0; req_wdata_b = '0; req_wstrb_b = 4'hF;
        rsp_ready_b = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        reset = 1'b0;

        // Write then read
        do_req("wr5", 1'b1, 32'd5, 32'hDEADBEEF, 4'hF, 32'd0, 1'b0, 0);
        do_req("rd5", 1'b0, 32'd5, 32'd0, 4'hF, 32'hDEADBEEF, 1'b0, 0);

        // Backpressure, stray writes to addr 5 must be ignored
        do_req("bp rd5", 1'b0, 32'd5, 32'd0, 4'hF, 32'hDEADBEEF, 1'b0, 5);
        do_req("rd5 after bp", 1'b0, 32'd5, 32'd0, 4'hF, 32'hDEADBEEF, 1'b0, 0);

        // Out of range and no aliasing
        do_req("wr0", 1'b1, 32'd0, 32'h0BADF00D, 4'hF, 32'd0, 1'b0, 0);
        do_req("wr3", 1'b1, 32'd3, 32'h33333333, 4'hF, 32'd0, 1'b0, 0);
        do_req("wr255", 1'b1, 32'd255, 32'h255255FF, 4'hF, 32'd0, 1'b0, 0);
        do_req("wr256 oor", 1'b1, 32'd256, 32'h12345678, 4'hF, 32'd0, 1'b1, 0);
        do_req("wr259 oor", 1'b1, 32'd259, 32'h87654321, 4'hF, 32'd0, 1'b1, 0);
        do_req("rd0", 1'b0, 32'd0, 32'd0, 4'hF, 32'h0BADF00D, 1'b0, 0);
        do_req("rd3", 1'b0, 32'd3, 32'd0, 4'hF, 32'h33333333, 1'b0, 0);
        do_req("rd255", 1'b0, 32'd255, 32'd0, 4'hF, 32'h255255FF, 1'b0, 0);
        do_req("rd top oor", 1'b0, 32'hFFFF_FFFF, 32'd0, 4'hF, 32'd0, 1'b1, 0);
        do_req("rd256 oor", 1'b0, 32'd256, 32'd0, 4'hF, 32'd0, 1'b1, 0);

        // Reset in WAIT aborts a pending write
        do_req("wr7 zero", 1'b1, 32'd7, 32'd0, 4'hF, 32'd0, 1'b0, 0);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 32'd7; req_wdata = 32'hA5A5A5A5; req_wstrb = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst wait rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst wait req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < LAT_A + 3; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        chk("rst wait no response", 32'(seen), 32'd0);
        do_req("rd7 after abort", 1'b0, 32'd7, 32'd0, 4'hF, 32'd0, 1'b0, 0);

        // Reset in RESP discards the response
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'd5;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        seen = 0;
        while (!rsp_valid && seen < 20) begin
            @(negedge clk);
            seen++;
        end
        chk("rst resp valid seen", 32'(rsp_valid), 32'd1);
        reset = 1'b1;
        #1;
        chk("rst resp rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst resp rsp_rdata", rsp_rdata, 32'd0);
        chk("rst resp req_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rst resp stays idle", 32'(rsp_valid), 32'd0);

        // Byte strobes
        do_req("wr9 preload", 1'b1, 32'd9, 32'h11223344, 4'hF, 32'd0, 1'b0, 0);
        do_req("wr9 strb", 1'b1, 32'd9, 32'hAABBCCDD, 4'b0101, 32'd0, 1'b0, 0);
`ifdef DMEM_RESPONDER_WSTRB_EN
        do_req("rd9 strb", 1'b0, 32'd9, 32'd0, 4'hF, 32'h11BB33DD, 1'b0, 0);
        do_req("wr9 nostrb", 1'b1, 32'd9, 32'hFFFFFFFF, 4'b0000, 32'd0, 1'b0, 0);
        do_req("rd9 nostrb", 1'b0, 32'd9, 32'd0, 4'hF, 32'h11BB33DD, 1'b0, 0);
`else
        do_req("rd9 full", 1'b0, 32'd9, 32'd0, 4'hF, 32'hAABBCCDD, 1'b0, 0);
`endif

        // LATENCY=1 back-to-back with rsp_ready tied high
        issued = 0; got = 0; last = -1; cyc = 0;
        rsp_ready_b = 1'b1;
        while (got < 12 && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid_b) begin
                if (sb_b.size() == 0) begin
                    chk("b spurious response", 32'd1, 32'd0);
                end else begin
                    e = sb_b.pop_front();
                    chk("b rdata", rsp_rdata_b, e.rdata);
                    chk("b err", 32'(rsp_err_b), 32'(e.err));
                end
                got++;
            end
            if (req_ready_b && issued < 12) begin
                if (last >= 0) chk("b accept spacing", 32'(cyc - last), 32'd3);
                last = cyc;
                req_valid_b = 1'b1;
                req_we_b    = (issued < 6);
                req_addr_b  = 32'(20 + (issued % 6));
                req_wdata_b = 32'hC0DE0000 + 32'(issued % 6);
                e.rdata = (issued < 6) ? 32'd0 : 32'hC0DE0000 + 32'(issued % 6);
                e.err   = 1'b0;
                sb_b.push_back(e);
                issued++;
            end else if (issued >= 12) begin
                req_valid_b = 1'b0;
            end
        end
        chk("b responses", 32'(got), 32'd12);
        chk("b scoreboard empty", 32'(sb_b.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 256, meaning the number of 32-bit words; it SHALL be a power of two between 16 and 4096.
REQ-002 SHALL have parameter LATENCY, default 2, meaning the number of clock edges from request accept to response valid; legal range is 1..15.
REQ-003 Port clk, input, 1, the single clock; all state SHALL update on the rising edge.
REQ-004 Port reset, input, 1; reset SHALL be asynchronous and active-high.
REQ-005 Port req_valid, input, 1, request present.
REQ-006 Port req_ready, output, 1, the responder can accept a request.
REQ-007 Port req_we, input, 1, 1=write and 0=read.
REQ-008 Port req_addr, input, 32, word address (PC-style, +1 per word).
REQ-009 Port req_wdata, input, 32, write data.
REQ-010 Port rsp_valid, output, 1, response present.
REQ-011 Port rsp_ready, input, 1, the initiator accepts the response.
REQ-012 Port rsp_rdata, output, 32, read data; it SHALL be 0 for writes and errors.
REQ-013 Port rsp_err, output, 1, the address was out of range.

Function
REQ-014 SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-015 In IDLE, req_ready SHALL be 1; in WAIT and RESP, req_ready SHALL be 0.
REQ-016 An accept SHALL occur at the rising edge where req_valid and req_ready are both 1.
REQ-017 At accept, the block SHALL latch we, addr and wdata, load counter = LATENCY-1, and move to WAIT.
REQ-018 In WAIT, at each edge, counter 0 SHALL move to RESP; otherwise the counter SHALL decrement.
REQ-019 rsp_valid SHALL rise exactly LATENCY edges after the accepting edge.
REQ-020 On the WAIT-to-RESP edge, the block SHALL commit the latched write to the array, or sample the array word into rsp_rdata for a read.
REQ-021 Out-of-range access (addr >= DEPTH) SHALL leave the array unmodified and set rsp_err=1 and rsp_rdata=0.
REQ-022 In-range access SHALL set rsp_err=0.
REQ-023 rsp_valid, rsp_rdata and rsp_err SHALL be registered, and SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-024 On an edge in RESP with rsp_ready=1, the block SHALL move to IDLE; req_ready SHALL be 1 in the following cycle.
REQ-025 Minimum spacing between accepts SHALL be LATENCY+2 cycles.
REQ-026 req_* changes while req_ready=0 SHALL be ignored.
REQ-027 rsp_ready=1 outside RESP SHALL be ignored.
REQ-028 Addresses SHALL compare as full 32-bit values, with no wrap-around; for example, DEPTH+3 SHALL be an error and SHALL NOT alias to word 3.

Reset
REQ-029 While reset=1, the block SHALL hold state=IDLE, counter=0, req_ready=1, rsp_valid=0, rsp_rdata=0 and rsp_err=0.
REQ-030 Reset asserted in WAIT SHALL abort the access; a pending write SHALL NOT be committed.
REQ-031 Reset asserted in RESP SHALL discard the response.
REQ-032 Array contents SHALL NOT be reset; a read of a never-written word returns an undefined value.

Configuration
REQ-033 With macro DMEM_RESPONDER_WSTRB_EN defined, the block SHALL add port req_wstrb, input, 4; a write SHALL update only the bytes whose strobe bit is 1, and strobe 4'b0000 SHALL be a no-write that still responds.
REQ-034 Without DMEM_RESPONDER_WSTRB_EN, the req_wstrb port SHALL be absent and every write SHALL update the full 32-bit word.

Structure
REQ-035 A shared package dmem_pkg SHALL hold the FSM state enum (IDLE/WAIT/RESP), the DATA_W=32 constant and the ADDR_W=32 constant.
REQ-036 Sub-module dmem_array SHALL hold the storage: single-port, synchronous write, with byte-strobe input tied to 4'b1111 when the macro is absent.
REQ-037 The FSM and counter SHALL reside in dmem_responder.

Verification
REQ-038 Write then read, LATENCY=2: write addr 5 with data 0xDEADBEEF, then read addr 5 -> each rsp_valid rises 2 edges after accept; read rsp_rdata=0xDEADBEEF and rsp_err=0.
REQ-039 Backpressure: hold rsp_ready=0 for 5 cycles during a read of addr 5 -> rsp_valid=1 and rsp_rdata=0xDEADBEEF stay stable, and req_ready stays 0 throughout.
REQ-040 Out of range, DEPTH=256: write addr 256 with 0x12345678, then read addr 0 -> the write gives rsp_err=1 and rsp_rdata=0; the read of addr 0 shows its prior value unchanged.
REQ-041 Reset mid-WAIT: accept a write of 0xA5A5A5A5 to addr 7, pulse reset 1 cycle later, then read addr 7 -> no response to the write; the read does not return 0xA5A5A5A5 (given addr 7 was pre-written with 0x0).
REQ-042 Macro defined: preload addr 9=0x11223344, write 0xAABBCCDD to addr 9 with req_wstrb=4'b0101 -> a read of addr 9 returns 0x11BB33DD.
REQ-043 LATENCY=1 back-to-back with rsp_ready tied to 1 -> accepts occur every 3 cycles and no request is dropped.
